// File: rtl/uart_frame_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser_pkg
// Description : Shared definitions for the UART level-frame parser: the frame
//               FSM state encoding, the default frame start marker and the
//               frame checksum function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_parser_pkg;

    // Default frame start marker
    localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame FSM state encoding
    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;  // await sync byte
    localparam logic [c_STATE_W-1:0] c_ST_GET_L = 2'd1;  // await left level
    localparam logic [c_STATE_W-1:0] c_ST_GET_R = 2'd2;  // await right level
    localparam logic [c_STATE_W-1:0] c_ST_GET_C = 2'd3;  // await checksum

    // Checksum carried in the last byte of a frame
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] sync_byte,
        input logic [7:0] left_level,
        input logic [7:0] right_level
    );
        return sync_byte ^ left_level ^ right_level;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module      : frame_timeout
// Description : Inter-byte timeout counter. Clears on i_clear, counts up while
//               i_enable is high and stops at MAX_CYCLES. o_expired is high
//               while enabled and the count sits at MAX_CYCLES.
// Ports       : i_clk     - clock, rising edge
//               i_rst_n   - asynchronous active-low reset
//               i_clear   - synchronous clear (priority over counting)
//               i_enable  - count enable
//               o_expired - count has reached MAX_CYCLES (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timeout #(
    parameter int MAX_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              WIDTH   = $clog2(MAX_CYCLES + 1);
    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(MAX_CYCLES);

    logic [WIDTH-1:0] r_count;

    // Counter saturates at the limit so it can never wrap back into range
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser
// Description : Parses 4-byte frames {SYNC_BYTE, L, R, C} from a UART byte
//               stream, C = SYNC_BYTE ^ L ^ R. Accepted frames update the
//               left/right level outputs; checksum errors and inter-byte
//               timeouts raise an error pulse. All outputs are registered.
// Ports       : i_clk       - clock, rising edge
//               i_rst_n     - asynchronous active-low reset
//               i_data[7:0] - received byte, valid when i_dv=1
//               i_dv        - byte strobe, one byte per cycle high
//               o_left[7:0] - last accepted left level
//               o_right[7:0]- last accepted right level
//               o_valid     - one-cycle pulse, new level pair accepted
//               o_err       - one-cycle pulse, checksum error or timeout
//               o_frame_cnt - accepted frame count, wraps
//               o_err_cnt   - error event count, saturates at 8'hFF
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SYNC_BYTE      = c_SYNC_BYTE_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_dv,
    output logic [7:0]  o_left,
    output logic [7:0]  o_right,
    output logic        o_valid,
    output logic        o_err,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);

    logic [c_STATE_W-1:0] r_state;
    logic [7:0]           r_left_cap;
    logic [7:0]           r_right_cap;
    logic [7:0]           r_left;
    logic [7:0]           r_right;
    logic                 r_valid;
    logic                 r_err;
    logic [15:0]          r_frame_cnt;
    logic [7:0]           r_err_cnt;

    logic w_idle;
    logic w_expired;
    logic w_timeout;
    logic w_cks_ok;
    logic w_cks_bad;
    logic w_err_event;

    assign w_idle = (r_state == c_ST_IDLE);

    frame_timeout #(
        .MAX_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_dv | w_idle),
        .i_enable  (!w_idle),
        .o_expired (w_expired)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign w_timeout   = w_expired && !i_dv;
    assign w_cks_ok    = (i_data == frame_checksum(SYNC_BYTE, r_left_cap, r_right_cap));
    assign w_cks_bad   = (r_state == c_ST_GET_C) && i_dv && !w_cks_ok;
    assign w_err_event = w_timeout || w_cks_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_left_cap  <= '0;
            r_right_cap <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= w_err_event;

            if (w_err_event && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (i_dv && (i_data == SYNC_BYTE)) begin
                            r_state <= c_ST_GET_L;
                        end
                    end
                    // SYNC_BYTE values inside a frame are plain data
                    c_ST_GET_L: begin
                        if (i_dv) begin
                            r_left_cap <= i_data;
                            r_state    <= c_ST_GET_R;
                        end
                    end
                    c_ST_GET_R: begin
                        if (i_dv) begin
                            r_right_cap <= i_data;
                            r_state     <= c_ST_GET_C;
                        end
                    end
                    c_ST_GET_C: begin
                        if (i_dv) begin
                            if (w_cks_ok) begin
                                r_left      <= r_left_cap;
                                r_right     <= r_right_cap;
                                r_valid     <= 1'b1;
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign o_left      = r_left;
    assign o_right     = r_right;
    assign o_valid     = r_valid;
    assign o_err       = r_err;
    assign o_frame_cnt = r_frame_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_parser
// Description : Directed self-checking bench for uart_frame_parser. Expected
//               valid/error events are queued when the closing byte is driven
//               and checked (kind, latency, levels, counters) when the DUT
//               pulses o_valid or o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int         TB_TIMEOUT = 20;
    localparam logic [7:0] TB_SYNC    = 8'hA5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv    = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic [7:0]  left;
    logic [7:0]  right;
    logic        valid;
    logic        err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    uart_frame_parser #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .SYNC_BYTE      (TB_SYNC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (data),
        .i_dv        (dv),
        .o_left      (left),
        .o_right     (right),
        .o_valid     (valid),
        .o_err       (err),
        .o_frame_cnt (frame_cnt),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] l;
        logic [7:0] r;
        int         stamp;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model of the architectural outputs
    logic [7:0]  m_left   = 8'h00;
    logic [7:0]  m_right  = 8'h00;
    logic [15:0] m_frames = 16'h0000;
    int          m_errs   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte strobe; called and returns at a falling edge
    task automatic drive(input logic [7:0] b);
        data = b;
        dv   = 1'b1;
        @(negedge clk);
        dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] r, input logic [7:0] c);
        logic [7:0] want;
        want = TB_SYNC ^ l ^ r;
        drive(TB_SYNC);
        drive(l);
        drive(r);
        sb_q.push_back('{is_err: (c !== want), l: l, r: r, stamp: cyc + 1});
        drive(c);
    endtask

    // Called right after the last byte strobe of a stalled frame
    task automatic expect_timeout();
        sb_q.push_back('{is_err: 1'b1, l: 8'h00, r: 8'h00, stamp: cyc + TB_TIMEOUT + 1});
    endtask

    task automatic drain();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", sb_q.size(), 0);
    endtask

    task automatic check_state(input string tag, input logic [7:0] l, input logic [7:0] r,
                               input logic [15:0] fc, input logic [7:0] ec);
        check({tag, "_left"},      left,      l);
        check({tag, "_right"},     right,     r);
        check({tag, "_frame_cnt"}, frame_cnt, fc);
        check({tag, "_err_cnt"},   err_cnt,   ec);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (valid || err)) begin
            check("valid_err_exclusive", 32'(valid & err), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_event", 32'({valid, err}), 0);
            end else begin
                e = sb_q.pop_front();
                check("event_latency", cyc, e.stamp);
                check("event_is_err", 32'(err), 32'(e.is_err));
                if (!e.is_err) begin
                    m_left  = e.l;
                    m_right = e.r;
                    m_frames++;
                end else begin
                    m_errs++;
                end
                check("ev_left",      left,      m_left);
                check("ev_right",     right,     m_right);
                check("ev_frame_cnt", frame_cnt, m_frames);
                check("ev_err_cnt",   err_cnt,   (m_errs > 255) ? 255 : m_errs);
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_state("reset", 8'h00, 8'h00, 16'd0, 8'd0);
        check("reset_valid", valid, 0);
        check("reset_err",   err,   0);

        // Basic frame, first byte on the first edge after release
        rst_n = 1'b1;
        send_frame(8'h37, 8'h03, 8'h91);
        drain();
        check_state("basic", 8'h37, 8'h03, 16'd1, 8'd0);

        // Leading garbage ignored
        drive(8'h12);
        drive(8'h34);
        send_frame(8'h37, 8'h03, 8'h91);
        drain();
        check_state("garbage", 8'h37, 8'h03, 16'd2, 8'd0);

        // Bad checksum holds levels
        send_frame(8'h10, 8'h20, 8'h00);
        drain();
        check_state("bad_cks", 8'h37, 8'h03, 16'd2, 8'd1);

        // Gaps of exactly TB_TIMEOUT idle cycles: byte lands on expiry cycle
        drive(TB_SYNC);
        idle(TB_TIMEOUT);
        drive(8'h5C);
        idle(TB_TIMEOUT);
        drive(8'hC3);
        idle(TB_TIMEOUT);
        sb_q.push_back('{is_err: 1'b0, l: 8'h5C, r: 8'hC3, stamp: cyc + 1});
        drive(TB_SYNC ^ 8'h5C ^ 8'hC3);
        drain();
        check_state("gap_edge", 8'h5C, 8'hC3, 16'd3, 8'd1);

        // Timeout in GET_R, then recovery
        drive(TB_SYNC);
        drive(8'h37);
        expect_timeout();
        idle(TB_TIMEOUT + 1);
        drain();
        check_state("timeout_r", 8'h5C, 8'hC3, 16'd3, 8'd2);
        send_frame(8'h55, 8'hAA, TB_SYNC ^ 8'h55 ^ 8'hAA);
        drain();
        check_state("recover", 8'h55, 8'hAA, 16'd4, 8'd2);

        // Timeout in GET_L and GET_C
        drive(TB_SYNC);
        expect_timeout();
        idle(TB_TIMEOUT + 1);
        drain();
        drive(TB_SYNC);
        drive(8'h01);
        drive(8'h02);
        expect_timeout();
        idle(TB_TIMEOUT + 1);
        drain();
        check_state("timeout_lc", 8'h55, 8'hAA, 16'd4, 8'd4);

        // Sync value as payload is data, not a restart
        send_frame(TB_SYNC, TB_SYNC, TB_SYNC);
        drain();
        check_state("sync_data", TB_SYNC, TB_SYNC, 16'd5, 8'd4);

        // Reset mid-frame discards the partial frame
        drive(TB_SYNC);
        drive(8'h37);
        rst_n = 1'b0;
        sb_q.delete();
        m_left   = 8'h00;
        m_right  = 8'h00;
        m_frames = 16'd0;
        m_errs   = 0;
        #1;
        check_state("async_rst", 8'h00, 8'h00, 16'd0, 8'd0);
        idle(3);
        rst_n = 1'b1;
        drive(8'h03);
        drive(8'h91);
        send_frame(8'h01, 8'h02, 8'hA6);
        drain();
        check_state("post_rst", 8'h01, 8'h02, 16'd1, 8'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            logic [7:0] l;
            l = 8'(i);
            send_frame(l, ~l, TB_SYNC ^ l ^ ~l ^ 8'h01);
        end
        drain();
        check_state("err_sat", 8'h01, 8'h02, 16'd1, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
